// File: rtl/ram_bus_cycle_if.sv
// 68000 bus / decoder / SRAM signal bundle seen by the bus-cycle sequencer.
// master = bus and decoder side, slave = sequencer.
interface ram_bus_cycle_if;
  logic _AS;
  logic _UDS;
  logic _LDS;
  logic RW;
  logic ram_sel;
  logic dtack_req;
  logic ovr_req;
  logic dtack_oe;
  logic ovr_oe;
  logic _RAMCE;
  logic _RAMOE;
  logic _RAMWE;
  logic _RAMUB;
  logic _RAMLB;
  logic busy;

  modport master (
    output _AS, _UDS, _LDS, RW, ram_sel, dtack_req, ovr_req,
    input  dtack_oe, ovr_oe, _RAMCE, _RAMOE, _RAMWE, _RAMUB, _RAMLB, busy
  );

  modport slave (
    input  _AS, _UDS, _LDS, RW, ram_sel, dtack_req, ovr_req,
    output dtack_oe, ovr_oe, _RAMCE, _RAMOE, _RAMWE, _RAMUB, _RAMLB, busy
  );
endinterface

// File: rtl/ram_bus_cycle.sv
// Bus-cycle sequencer: times decoder requests against the 68000 strobes and
// drives the _DTACK/_OVR open-drain enables plus the SRAM control strobes.
module ram_bus_cycle #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WE_HOLDOFF  = 1
) (
  input logic             CLK,
  input logic             _RST,
  ram_bus_cycle_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  localparam logic [2:0] WaitInit = 3'(WAIT_STATES);
  localparam logic [1:0] WeHold   = 2'(WE_HOLDOFF);

  state_e      state_q;
  logic [2:0]  wait_cnt_q;
  logic [1:0]  we_cnt_q;
  logic        sel_q;
  logic        busy_q;

  logic as_on;
  logic strobe_on;
  logic active;
  logic ram_on;
  logic wr_cond;
  logic we_ready;

  assign as_on     = !bus._AS;
  assign strobe_on = !bus._UDS || !bus._LDS;
  assign active    = (state_q != StIdle);
  assign ram_on    = sel_q && active;
  assign wr_cond   = ram_on && !bus.RW && as_on && strobe_on;
  // we_cnt >= WE_HOLDOFF, phrased so a zero holdoff is not a constant compare
  assign we_ready  = ({1'b0, we_cnt_q} + 3'd1) > {1'b0, WeHold};

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q    <= StIdle;
      wait_cnt_q <= 3'd0;
      we_cnt_q   <= 2'd0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (as_on && bus.dtack_req) begin
            state_q    <= StWait;
            wait_cnt_q <= WaitInit;
            sel_q      <= bus.ram_sel;
            busy_q     <= 1'b1;
          end
        end
        StWait: begin
          if (!as_on) begin
            state_q    <= StIdle;
            wait_cnt_q <= 3'd0;
            busy_q     <= 1'b0;
          end else if (wait_cnt_q == 3'd0) begin
            state_q <= StAck;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StAck: begin
          if (!as_on) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      // Edges seen with the write strobe held; saturates rather than wrapping
      if (!wr_cond) begin
        we_cnt_q <= 2'd0;
      end else if (we_cnt_q != 2'd3) begin
        we_cnt_q <= we_cnt_q + 2'd1;
      end
    end
  end

  assign bus.dtack_oe = (state_q == StAck) && as_on;
  // Gated by reset so the override releases without waiting for a clock
  assign bus.ovr_oe   = _RST && bus.ovr_req && as_on;
  assign bus._RAMCE   = !(ram_on && as_on);
  assign bus._RAMOE   = !(ram_on && bus.RW && as_on);
  assign bus._RAMUB   = !(ram_on && !bus._UDS);
  assign bus._RAMLB   = !(ram_on && !bus._LDS);
  assign bus._RAMWE   = !(wr_cond && we_ready);
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_bus_cycle.sv
// Bench for ram_bus_cycle: three parameterisations share one stimulus stream and are
// compared every half cycle against an edge-counting model of the bus cycle.
module tb_ram_bus_cycle;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic sel = 1'b0, dreq = 1'b0, ovr = 1'b0;

  logic [2:0] o_dtack, o_ovr, o_ce, o_oe, o_we, o_ub, o_lb, o_busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int unsigned ws_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  function automatic int unsigned hold_of(int i);
    return (i == 2) ? 0 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_bus_cycle_if bus_if ();
    assign bus_if._AS       = as_n;
    assign bus_if._UDS      = uds_n;
    assign bus_if._LDS      = lds_n;
    assign bus_if.RW        = rw;
    assign bus_if.ram_sel   = sel;
    assign bus_if.dtack_req = dreq;
    assign bus_if.ovr_req   = ovr;
    assign o_dtack[g] = bus_if.dtack_oe;
    assign o_ovr[g]   = bus_if.ovr_oe;
    assign o_ce[g]    = bus_if._RAMCE;
    assign o_oe[g]    = bus_if._RAMOE;
    assign o_we[g]    = bus_if._RAMWE;
    assign o_ub[g]    = bus_if._RAMUB;
    assign o_lb[g]    = bus_if._RAMLB;
    assign o_busy[g]  = bus_if.busy;

    ram_bus_cycle #(
      .WAIT_STATES (ws_of(g)),
      .WE_HOLDOFF  (hold_of(g))
    ) u_dut (
      .CLK  (clk),
      ._RST (rst_n),
      .bus  (bus_if.slave)
    );
  end

  // Model: a cycle is "active" from the edge that samples the request until the
  // edge that sees _AS high; age counts edges since that sampling edge.
  bit m_active [3];
  bit m_sel    [3];
  int m_age    [3];
  int m_wcnt   [3];

  function automatic bit m_wr(int i);
    return m_active[i] && m_sel[i] && !rw && !as_n && (!uds_n || !lds_n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_active[i] <= 1'b0;
        m_age[i]    <= 0;
        m_wcnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_wcnt[i] <= m_wr(i) ? ((m_wcnt[i] < 3) ? m_wcnt[i] + 1 : 3) : 0;
        if (!m_active[i]) begin
          if (!as_n && dreq) begin
            m_active[i] <= 1'b1;
            m_age[i]    <= 0;
            m_sel[i]    <= sel;
          end
        end else if (as_n) begin
          m_active[i] <= 1'b0;
        end else if (m_age[i] < 100) begin
          m_age[i] <= m_age[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got %b, expected %b", name, idx, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      bit base;
      bit as_on;
      base  = m_active[i] && m_sel[i];
      as_on = !as_n;
      chk("dtack_oe", i, o_dtack[i], m_active[i] && (m_age[i] >= int'(ws_of(i)) + 1) && as_on);
      chk("ovr_oe",   i, o_ovr[i],   rst_n && ovr && as_on);
      chk("_RAMCE",   i, o_ce[i],    !(base && as_on));
      chk("_RAMOE",   i, o_oe[i],    !(base && rw && as_on));
      chk("_RAMUB",   i, o_ub[i],    !(base && !uds_n));
      chk("_RAMLB",   i, o_lb[i],    !(base && !lds_n));
      chk("_RAMWE",   i, o_we[i],
          !(base && !rw && as_on && (!uds_n || !lds_n) && (m_wcnt[i] >= int'(hold_of(i)))));
      chk("busy",     i, o_busy[i],  m_active[i]);
    end
  endtask

  // Stimulus moves between +3 and +6 after each edge; compare well clear of it
  always @(posedge clk) begin
    #1 compare_all();
    #8 compare_all();
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic bus_idle();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    sel = 1'b0; dreq = 1'b0; ovr = 1'b0;
  endtask

  initial begin
    bus_idle();
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_dtack", 0, o_dtack[0], 1'b0);
    chk("rst_ce",    0, o_ce[0],    1'b1);
    chk("rst_we",    0, o_we[0],    1'b1);
    chk("rst_busy",  0, o_busy[0],  1'b0);
    rst_n = 1'b1;

    // Read, RAM target
    tick();
    as_n = 1'b0; sel = 1'b1; dreq = 1'b1; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    tick(); #1;
    chk("rd_ce_e1",    0, o_ce[0],    1'b0);
    chk("rd_oe_e1",    0, o_oe[0],    1'b0);
    chk("rd_dtack_e1", 0, o_dtack[0], 1'b0);
    chk("rd_busy_e1",  1, o_busy[1],  1'b1);
    tick(); #1;
    chk("rd_dtack_e2", 0, o_dtack[0], 1'b1);
    chk("ws2_dtack_e2", 1, o_dtack[1], 1'b0);
    tick(); #1;
    chk("ws2_dtack_e3", 1, o_dtack[1], 1'b0);
    chk("ws2_busy_e3",  1, o_busy[1],  1'b1);
    tick(); #1;
    chk("ws2_dtack_e4", 1, o_dtack[1], 1'b1);
    chk("ws3_dtack_e4", 2, o_dtack[2], 1'b0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    #1;
    chk("rd_rel_dtack", 0, o_dtack[0], 1'b0);
    chk("rd_rel_ce",    0, o_ce[0],    1'b1);
    chk("rd_rel_oe",    0, o_oe[0],    1'b1);
    tick(); #1;
    chk("rd_idle_busy", 0, o_busy[0], 1'b0);

    // Write, lower byte only
    as_n = 1'b0; rw = 1'b0; sel = 1'b1; dreq = 1'b1;
    tick();
    lds_n = 1'b0;
    #1;
    chk("wr_lb",       0, o_lb[0], 1'b0);
    chk("wr_ub",       0, o_ub[0], 1'b1);
    chk("wr_we_early", 0, o_we[0], 1'b1);
    chk("wr_we_h0",    2, o_we[2], 1'b0);
    tick(); #1;
    chk("wr_we_low", 0, o_we[0], 1'b0);
    lds_n = 1'b1;
    #1;
    chk("wr_we_rise", 0, o_we[0], 1'b1);
    chk("wr_lb_rise", 0, o_lb[0], 1'b1);
    as_n = 1'b1; rw = 1'b1;
    tick(); #1;
    chk("wr_idle_busy", 2, o_busy[2], 1'b0);

    // Autoconfig read: DTACK without SRAM strobes
    as_n = 1'b0; sel = 1'b0; dreq = 1'b1; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    tick();
    tick(); #1;
    chk("ac_dtack", 0, o_dtack[0], 1'b1);
    chk("ac_ce",    0, o_ce[0],    1'b1);
    chk("ac_oe",    0, o_oe[0],    1'b1);
    chk("ac_we",    0, o_we[0],    1'b1);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick();

    // Abort during wait states, then a clean cycle
    as_n = 1'b0; sel = 1'b1; dreq = 1'b1; rw = 1'b1;
    tick();
    tick();
    as_n = 1'b1;
    #1;
    chk("ab_ce",    2, o_ce[2],    1'b1);
    chk("ab_dtack", 2, o_dtack[2], 1'b0);
    tick(); #1;
    chk("ab_busy", 2, o_busy[2], 1'b0);
    as_n = 1'b0;
    tick(); #1;
    chk("ab_new_busy", 2, o_busy[2], 1'b1);
    tick();
    tick();
    tick(); #1;
    chk("ab_new_dtack_e4", 2, o_dtack[2], 1'b0);
    tick(); #1;
    chk("ab_new_dtack_e5", 2, o_dtack[2], 1'b1);
    as_n = 1'b1;
    tick();

    // Async reset in ACK with override pending
    as_n = 1'b0; sel = 1'b1; dreq = 1'b1; ovr = 1'b1; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    #1;
    chk("ovr_early", 0, o_ovr[0], 1'b1);
    tick();
    tick(); #1;
    chk("rs_dtack_pre", 0, o_dtack[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rs_dtack", 0, o_dtack[0], 1'b0);
    chk("rs_ovr",   0, o_ovr[0],   1'b0);
    chk("rs_ce",    0, o_ce[0],    1'b1);
    chk("rs_oe",    0, o_oe[0],    1'b1);
    chk("rs_ub",    0, o_ub[0],    1'b1);
    chk("rs_lb",    0, o_lb[0],    1'b1);
    chk("rs_busy",  0, o_busy[0],  1'b0);
    bus_idle();
    tick();
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 4) == 0) as_n = ~as_n;
      if ($urandom_range(0, 3) == 0) uds_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) lds_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rw    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) sel   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) dreq  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) ovr   = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 299) != 0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
